cdb_arbiter: RTL and testbench

Writeback arbiter between the functional units (ALU, branch, LSU, plus spare ports) and the Common Data Bus broadcast slots. The CDB feeds the dispatch stage's lost-wakeup check, the reservation stations, the PRF ready table and the ROB. Each FU result is captured in a per-port holding register. Up to NUM_CDB held results are granted per cycle in round-robin order and driven onto the CDB slots. On mispredict, held results younger than the branch are squashed.

---
 rtl/cdb_arbiter_pkg.sv | 25 ++
 rtl/cdb_arbiter_if.sv | 26 ++
 rtl/cdb_arbiter_hold_reg.sv | 31 +++
 rtl/cdb_arbiter.sv | 90 +++++++++
 tb/tb_cdb_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the CDB writeback arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned PREG_W = 7;
    localparam int unsigned ROB_W  = 5;

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic [ROB_W-1:0]  rob_tag;
        logic [31:0]       data;
        logic              has_dest;
    } cdb_pkt_t;

    // True when tag is strictly younger than ref_tag, ages measured from the ROB head.
    function automatic logic rob_younger(input logic [ROB_W-1:0] tag,
                                         input logic [ROB_W-1:0] ref_tag,
                                         input logic [ROB_W-1:0] head);
        logic [ROB_W-1:0] age_tag;
        logic [ROB_W-1:0] age_ref;
        age_tag = tag - head;
        age_ref = ref_tag - head;
        return age_tag > age_ref;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result ports, CDB broadcast slots and flush controls of the arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_CDB = 3
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    cdb_pkt_t [NUM_REQ-1:0]       req_pkt;
    logic [NUM_CDB-1:0]           cdb_valid;
    cdb_pkt_t [NUM_CDB-1:0]       cdb_pkt;
    logic                         mispredict;
    logic [ROB_W-1:0]             mispredict_tag;
    logic [ROB_W-1:0]             rob_head;

    modport master (
        output req_valid, req_pkt, mispredict, mispredict_tag, rob_head,
        input  req_ready, cdb_valid, cdb_pkt
    );

    modport slave (
        input  req_valid, req_pkt, mispredict, mispredict_tag, rob_head,
        output req_ready, cdb_valid, cdb_pkt
    );
endinterface

// File: rtl/cdb_arbiter_hold_reg.sv
// Per-port result holding register: loads on accept, clears on grant or kill.
module cdb_hold_reg
    import cdb_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     accept,
    input  logic     drop_in,
    input  logic     grant,
    input  logic     kill,
    input  cdb_pkt_t in_pkt,
    output logic     hold_valid,
    output cdb_pkt_t hold_pkt
);

    // Accept has priority: a port only accepts when empty or draining this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_pkt   <= '0;
        end else if (accept) begin
            hold_valid <= !drop_in;
            if (!drop_in) begin
                hold_pkt <= in_pkt;
            end
        end else if (grant || kill) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin multi-grant writeback arbiter driving the CDB broadcast slots.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_CDB = 3
)(
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SLOT_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    logic [NUM_REQ-1:0] hold_valid;
    cdb_pkt_t           hold_pkt [NUM_REQ];
    logic [NUM_REQ-1:0] kill;
    logic [NUM_REQ-1:0] drop_in;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic               ready_en;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        cdb_hold_reg u_hold (
            .clk        (clk),
            .reset      (reset),
            .accept     (accept[i]),
            .drop_in    (drop_in[i]),
            .grant      (grant[i]),
            .kill       (kill[i]),
            .in_pkt     (bus.req_pkt[i]),
            .hold_valid (hold_valid[i]),
            .hold_pkt   (hold_pkt[i])
        );
    end

    // Flush qualification of held entries and incoming results, plus port handshake.
    always_comb begin
        kill    = '0;
        drop_in = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            kill[i]    = bus.mispredict &&
                         rob_younger(hold_pkt[i].rob_tag, bus.mispredict_tag, bus.rob_head);
            drop_in[i] = bus.mispredict &&
                         rob_younger(bus.req_pkt[i].rob_tag, bus.mispredict_tag, bus.rob_head);
        end
        elig          = hold_valid & ~kill;
        bus.req_ready = ready_en ? (~hold_valid | grant) : '0;
        accept        = bus.req_valid & bus.req_ready;
    end

    // Scan from rr_ptr, granting the first NUM_CDB eligible holds into slots in scan order.
    always_comb begin
        logic [PTR_W-1:0] last_idx;
        logic [PTR_W-1:0] idx;
        int unsigned      n;
        grant         = '0;
        bus.cdb_valid = '0;
        bus.cdb_pkt   = '0;
        last_idx      = rr_ptr;
        n             = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(rr_ptr) + off) % NUM_REQ);
            if (elig[idx] && (n < NUM_CDB)) begin
                grant[idx]                  = 1'b1;
                bus.cdb_valid[SLOT_W'(n)]   = 1'b1;
                bus.cdb_pkt[SLOT_W'(n)]     = hold_pkt[idx];
                last_idx                    = idx;
                n                           = n + 1;
            end
        end
        rr_next = (|grant) ? PTR_W'((32'(last_idx) + 1) % NUM_REQ) : rr_ptr;
    end

    // Round-robin pointer and the post-reset ready enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            rr_ptr   <= rr_next;
            ready_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for the CDB writeback arbiter.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned NC = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(NR), .NUM_CDB(NC)) bus ();

    cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string    tag;
        logic     v;
        cdb_pkt_t p;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic cdb_pkt_t mk(input int unsigned preg, input int unsigned tag,
                                    input logic [31:0] data, input logic hd);
        cdb_pkt_t r;
        r.preg     = preg[PREG_W-1:0];
        r.rob_tag  = tag[ROB_W-1:0];
        r.data     = data;
        r.has_dest = hd;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_slot(input string tag, input logic v, input cdb_pkt_t p);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.p   = v ? p : '0;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input string tag);
        for (int unsigned s = 0; s < NC; s++) push_slot(tag, 1'b0, '0);
    endtask

    task automatic check_cdb();
        exp_t e;
        for (int unsigned s = 0; s < NC; s++) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_empty slot%0d: got no expectation, required one", s);
            end else begin
                e = exp_q.pop_front();
                tests++;
                assert (bus.cdb_valid[s[1:0]] === e.v) else begin
                    fails++;
                    $error("FAIL %s slot%0d valid: got %b required %b",
                           e.tag, s, bus.cdb_valid[s[1:0]], e.v);
                end
                tests++;
                assert (bus.cdb_pkt[s[1:0]] === e.p) else begin
                    fails++;
                    $error("FAIL %s slot%0d pkt: got %h required %h",
                           e.tag, s, bus.cdb_pkt[s[1:0]], e.p);
                end
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    cdb_pkt_t    pa [NR];
    int unsigned sched [4][3];
    int unsigned gap [NR];
    logic        seen;

    initial begin
        sched = '{'{0, 1, 2}, '{3, 0, 1}, '{2, 3, 0}, '{1, 2, 3}};
        reset              = 1'b0;
        bus.req_valid      = '0;
        bus.req_pkt        = '0;
        bus.mispredict     = 1'b0;
        bus.mispredict_tag = '0;
        bus.rob_head       = '0;

        // Reset state
        tick();
        tick();
        push_idle("rst_idle");
        check_cdb();
        check_val("rst_ready", 8'(bus.req_ready), 8'h0);
        reset = 1'b1;
        tick();
        check_val("ready_after_rst", 8'(bus.req_ready), 8'h0f);
        push_idle("post_rst_idle");
        check_cdb();

        // Single result on port 0, one-cycle latency
        pa[0] = mk(12, 3, 32'h1234_5678, 1'b1);
        bus.req_pkt[0] = pa[0];
        bus.req_valid  = 4'b0001;
        push_slot("single", 1'b1, pa[0]);
        push_slot("single", 1'b0, '0);
        push_slot("single", 1'b0, '0);
        tick();
        bus.req_valid = '0;
        check_cdb();
        check_val("single_ready0", 8'(bus.req_ready[0]), 8'h1);
        tick();
        push_idle("single_drain");
        check_cdb();

        // Store result without destination, rr_ptr now 1
        pa[1] = mk(0, 7, 32'hdead_beef, 1'b0);
        bus.req_pkt[1] = pa[1];
        bus.req_valid  = 4'b0010;
        push_slot("store", 1'b1, pa[1]);
        push_slot("store", 1'b0, '0);
        push_slot("store", 1'b0, '0);
        tick();
        bus.req_valid = '0;
        check_cdb();
        tick();
        push_idle("store_drain");
        check_cdb();

        // rr_ptr now 2: three holds broadcast in order 2,0,1, then async reset
        for (int unsigned i = 0; i < 3; i++) begin
            pa[i] = mk(20 + i, 10 + i, 32'h100 + i, 1'b1);
            bus.req_pkt[i] = pa[i];
        end
        bus.req_valid = 4'b0111;
        push_slot("rr2", 1'b1, pa[2]);
        push_slot("rr2", 1'b1, pa[0]);
        push_slot("rr2", 1'b1, pa[1]);
        tick();
        bus.req_valid = '0;
        check_cdb();
        #2 reset = 1'b0;
        #1;
        push_idle("async_rst");
        check_cdb();
        check_val("async_rst_ready", 8'(bus.req_ready), 8'h0);
        tick();
        reset = 1'b1;
        tick();
        check_val("ready_after_midrst", 8'(bus.req_ready), 8'h0f);
        push_idle("midrst_cleared");
        check_cdb();

        // All four ports with rr_ptr back at 0
        for (int unsigned i = 0; i < NR; i++) begin
            pa[i] = mk(30 + i, 16 + i, 32'h200 + i, 1'b1);
            bus.req_pkt[i] = pa[i];
        end
        bus.req_valid = 4'b1111;
        push_slot("all4_c1", 1'b1, pa[0]);
        push_slot("all4_c1", 1'b1, pa[1]);
        push_slot("all4_c1", 1'b1, pa[2]);
        tick();
        bus.req_valid = '0;
        check_cdb();
        check_val("all4_ready", 8'(bus.req_ready), 8'h07);
        push_slot("all4_c2", 1'b1, pa[3]);
        push_slot("all4_c2", 1'b0, '0);
        push_slot("all4_c2", 1'b0, '0);
        tick();
        check_cdb();
        tick();
        push_idle("all4_drain");
        check_cdb();

        // Saturation: every port re-offers each cycle, rotation and no starvation
        for (int unsigned i = 0; i < NR; i++) begin
            pa[i] = mk(40 + i, 0, 32'h300 + i, 1'b1);
            bus.req_pkt[i] = pa[i];
            gap[i] = 0;
        end
        bus.req_valid = 4'b1111;
        for (int unsigned c = 0; c < 8; c++) begin
            for (int unsigned k = 0; k < NC; k++) begin
                push_slot("sat", 1'b1, pa[sched[c % 4][k]]);
            end
            tick();
            check_cdb();
            for (int unsigned i = 0; i < NR; i++) begin
                seen = 1'b0;
                for (int unsigned s = 0; s < NC; s++) begin
                    if (bus.cdb_valid[s[1:0]] && (bus.cdb_pkt[s[1:0]].preg == pa[i].preg))
                        seen = 1'b1;
                end
                gap[i] = seen ? 0 : gap[i] + 1;
                check_val("starve", 8'(gap[i] < 2), 8'h1);
            end
        end
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        push_idle("sat_drain");
        check_cdb();

        // Flush: head 30, branch tag 1; tags 31 and 1 survive, 2 and incoming 4 die
        bus.rob_head       = 5'd30;
        bus.mispredict_tag = 5'd1;
        pa[0] = mk(50, 31, 32'h400, 1'b1);
        pa[1] = mk(51, 1,  32'h401, 1'b1);
        pa[2] = mk(52, 2,  32'h402, 1'b1);
        pa[3] = mk(53, 4,  32'h403, 1'b1);
        for (int unsigned i = 0; i < NR; i++) bus.req_pkt[i] = pa[i];
        bus.req_valid = 4'b0111;
        tick();
        bus.req_valid  = 4'b1000;
        bus.mispredict = 1'b1;
        #1;
        push_slot("flush", 1'b1, pa[1]);
        push_slot("flush", 1'b1, pa[0]);
        push_slot("flush", 1'b0, '0);
        check_cdb();
        check_val("flush_ready", 8'(bus.req_ready), 8'h0b);
        tick();
        bus.mispredict = 1'b0;
        bus.req_valid  = '0;
        push_idle("flush_after");
        check_cdb();
        tick();
        push_idle("flush_after2");
        check_cdb();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
